instr_decode: RTL

INSTR_DECODE -- requirements
Module: instr_decode

---
 rtl/instr_decode.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instr_decode.sv
// Instruction decode stage: decodes on entry into a 2-entry skid buffer and
// presents the oldest entry downstream with a valid/ready handshake.
module instr_decode #(
   parameter logic [5:0] ILLEGAL_OPC_MIN = 6'd40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] instr,
   input  logic [7:0]  next_PC,
   output logic        in_ready,
   input  logic        flush,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  funct,
   output logic [31:0] imm32,
   output logic [7:0]  pc_out,
   output logic [7:0]  br_target,
   output logic        is_branch,
   output logic        illegal,
   output logic [15:0] dec_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  funct;
      logic [31:0] imm32;
      logic [7:0]  pc;
      logic [7:0]  br_target;
      logic        is_branch;
      logic        illegal;
   } entry_t;

   state_t      state_reg, state_next;
   entry_t      head_reg, head_next;
   entry_t      tail_reg, tail_next;
   entry_t      dec_entry;
   logic [15:0] count_reg, count_next;
   logic        accept;
   logic        deliver;

   // Occupancy alone drives the handshake, so in_ready never sees out_ready.
   assign in_ready  = (state_reg != TWO);
   assign out_valid = (state_reg != EMPTY);
   assign accept    = in_valid && in_ready;
   assign deliver   = out_valid && out_ready;

   always_comb begin
      dec_entry           = '0;
      dec_entry.opcode    = instr[31:26];
      dec_entry.rs        = instr[25:21];
      dec_entry.rt        = instr[20:16];
      dec_entry.funct     = instr[4:0];
      dec_entry.imm32     = {{16{instr[15]}}, instr[15:0]};
      dec_entry.pc        = next_PC;
      dec_entry.br_target = instr[7:0];
      dec_entry.is_branch = (instr[31:29] == 3'b100);
      dec_entry.illegal   = (instr[31:26] >= ILLEGAL_OPC_MIN);
   end

   always_comb begin
      state_next = state_reg;
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (flush) begin
         state_next = EMPTY;
      end else begin
         if (deliver && (count_reg != 16'hFFFF))
            count_next = count_reg + 16'd1;
         unique case (state_reg)
            EMPTY: begin
               if (accept) begin
                  head_next  = dec_entry;
                  state_next = ONE;
               end
            end
            ONE: begin
               // Simultaneous accept+deliver replaces the head in place.
               if (accept && deliver) begin
                  head_next = dec_entry;
               end else if (accept) begin
                  tail_next  = dec_entry;
                  state_next = TWO;
               end else if (deliver) begin
                  state_next = EMPTY;
               end
            end
            TWO: begin
               if (deliver) begin
                  head_next  = tail_reg;
                  state_next = ONE;
               end
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= EMPTY;
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   assign opcode    = head_reg.opcode;
   assign rs        = head_reg.rs;
   assign rt        = head_reg.rt;
   assign funct     = head_reg.funct;
   assign imm32     = head_reg.imm32;
   assign pc_out    = head_reg.pc;
   assign br_target = head_reg.br_target;
   assign is_branch = head_reg.is_branch;
   assign illegal   = head_reg.illegal;
   assign dec_count = count_reg;

endmodule
